// File: rtl/sb_io.sv
// Single-bit bidirectional pad cell: tri-state output, input path and optional
// input/output/OE registers selected by PIN_TYPE. Define SB_IO_DDR_EN to build the falling-edge (DDR) registers.
module sb_io #(
  parameter logic [5:0] PIN_TYPE = 6'b000000,
  parameter logic       PULLUP   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  inout  wire  package_pin,
  input  logic clock_enable,
  input  logic latch_input_value,
  input  logic output_enable,
  input  logic d_out_0,
  input  logic d_out_1,
  output logic d_in_0,
  output logic d_in_1
);

  localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
  localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
  localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];

  logic pin_in;
  logic pin_held;
  logic in_hold;
  logic q0;
  logic oe_q;
  logic in0_q;
  logic ddr_data;
  logic pin_data;
  logic drive;

  assign pin_in  = package_pin;
  assign in_hold = IN_MODE[1] & latch_input_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      q0    <= 1'b0;
      oe_q  <= 1'b0;
      in0_q <= 1'b0;
    end else if (clock_enable) begin
      q0   <= d_out_0;
      oe_q <= output_enable;
      if (!in_hold) in0_q <= pin_in;
    end
  end

`ifdef SB_IO_DDR_EN
  logic q1;
  logic in1_q;

  always_ff @(negedge clk) begin
    if (reset) begin
      q1    <= 1'b0;
      in1_q <= 1'b0;
    end else if (clock_enable) begin
      q1 <= d_out_1;
      if (!in_hold) in1_q <= pin_in;
    end
  end

  // q0 owns the high half of the cycle, q1 the low half
  assign ddr_data = clk ? q0 : q1;
  assign d_in_1   = IN_MODE[0] ? 1'b0 : in1_q;
`else
  logic unused_ddr;

  assign unused_ddr = d_out_1;
  assign ddr_data   = q0;
  assign d_in_1     = 1'b0;
`endif

  // Direct-latched input is a true transparent latch; other modes need none
  generate
    if (IN_MODE == 2'b11) begin : g_in_latch
      always_latch begin
        if (!latch_input_value) pin_held = pin_in;
      end
    end else begin : g_no_latch
      assign pin_held = pin_in;
    end
  endgenerate

  always_comb begin
    pin_data = q0;
    unique case (OUT_MODE)
      2'b00: pin_data = ddr_data;
      2'b01: pin_data = q0;
      2'b10: pin_data = d_out_0;
      2'b11: pin_data = ~q0;
    endcase
  end

  always_comb begin
    drive = 1'b0;
    unique case (OE_MODE)
      2'b00: drive = 1'b0;
      2'b01: drive = 1'b1;
      2'b10: drive = output_enable;
      2'b11: drive = oe_q;
    endcase
  end

  always_comb begin
    d_in_0 = in0_q;
    unique case (IN_MODE)
      2'b00: d_in_0 = in0_q;
      2'b01: d_in_0 = pin_in;
      2'b10: d_in_0 = in0_q;
      2'b11: d_in_0 = pin_held;
    endcase
  end

  assign package_pin = drive ? pin_data : 1'bz;

  generate
    if (PULLUP) begin : g_pullup
      pullup (package_pin);
    end
  endgenerate

endmodule

// File: tb/tb_sb_io.sv
// Directed bench for sb_io: several instances, each with a different PIN_TYPE.
module tb_sb_io;

`ifdef SB_IO_DDR_EN
  localparam logic DDR = 1'b1;
`else
  localparam logic DDR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ce;
  logic zero;

  logic a_oe, a_d0, a_ext_en, a_ext_val;
  logic b_oe, b_d0, b_ce;
  logic c_d0, c_d1;
  logic d_val, d_latch;

  wire pin_a, pin_b, pin_c, pin_d, pin_e;
  logic a_din0, a_din1, b_din0, b_din1, c_din0, c_din1;
  logic d_din0, d_din1, e_din0, e_din1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign pin_a = a_ext_en ? a_ext_val : 1'bz;
  assign pin_d = d_val;

  sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b0)) u_a (
    .clk(clk), .reset(reset), .package_pin(pin_a), .clock_enable(ce),
    .latch_input_value(zero), .output_enable(a_oe), .d_out_0(a_d0),
    .d_out_1(zero), .d_in_0(a_din0), .d_in_1(a_din1)
  );

  sb_io #(.PIN_TYPE(6'b110100), .PULLUP(1'b0)) u_b (
    .clk(clk), .reset(reset), .package_pin(pin_b), .clock_enable(b_ce),
    .latch_input_value(zero), .output_enable(b_oe), .d_out_0(b_d0),
    .d_out_1(zero), .d_in_0(b_din0), .d_in_1(b_din1)
  );

  sb_io #(.PIN_TYPE(6'b010000), .PULLUP(1'b0)) u_c (
    .clk(clk), .reset(reset), .package_pin(pin_c), .clock_enable(ce),
    .latch_input_value(zero), .output_enable(zero), .d_out_0(c_d0),
    .d_out_1(c_d1), .d_in_0(c_din0), .d_in_1(c_din1)
  );

  sb_io #(.PIN_TYPE(6'b000010), .PULLUP(1'b0)) u_d (
    .clk(clk), .reset(reset), .package_pin(pin_d), .clock_enable(ce),
    .latch_input_value(d_latch), .output_enable(zero), .d_out_0(zero),
    .d_out_1(zero), .d_in_0(d_din0), .d_in_1(d_din1)
  );

  sb_io #(.PIN_TYPE(6'b000001), .PULLUP(1'b1)) u_e (
    .clk(clk), .reset(reset), .package_pin(pin_e), .clock_enable(ce),
    .latch_input_value(zero), .output_enable(zero), .d_out_0(zero),
    .d_out_1(zero), .d_in_0(e_din0), .d_in_1(e_din1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; zero = 1'b0;
    a_oe = 1'b0; a_d0 = 1'b0; a_ext_en = 1'b0; a_ext_val = 1'b0;
    b_oe = 1'b0; b_d0 = 1'b0; b_ce = 1'b1;
    c_d0 = 1'b0; c_d1 = 1'b0;
    d_val = 1'b0; d_latch = 1'b0;
    tick();
    tick();

    chk("rst_b_hiz", u_b.drive, 1'b0);
    chk("rst_b_din0", b_din0, 1'b0);
    chk("rst_c_pin", pin_c, 1'b0);
    chk("rst_c_din0", c_din0, 1'b0);
    chk("rst_d_hiz", u_d.drive, 1'b0);
    chk("pullup_e_din0", e_din0, 1'b1);
    reset = 1'b0;

    // A: fully combinational path
    a_oe = 1'b1; a_d0 = 1'b1; #1;
    chk("a_pin_1", pin_a, 1'b1);
    chk("a_din0_1", a_din0, 1'b1);
    a_d0 = 1'b0; #1;
    chk("a_pin_0", pin_a, 1'b0);
    chk("a_din0_0", a_din0, 1'b0);
    a_oe = 1'b0; #1;
    chk("a_hiz", u_a.drive, 1'b0);
    a_ext_en = 1'b1; a_ext_val = 1'b1; #1;
    chk("a_ext_din0_1", a_din0, 1'b1);
    a_ext_val = 1'b0; #1;
    chk("a_ext_din0_0", a_din0, 1'b0);
    a_ext_en = 1'b0;

    // B: registered OE and data, registered input
    tick();
    b_oe = 1'b1; b_d0 = 1'b1; #1;
    chk("b_hiz_before_edge", u_b.drive, 1'b0);
    tick();
    chk("b_drive_edge_n", u_b.drive, 1'b1);
    chk("b_pin_edge_n", pin_b, 1'b1);
    tick();
    chk("b_din0_edge_n1", b_din0, 1'b1);
    b_ce = 1'b0; b_d0 = 1'b0; b_oe = 1'b0;
    tick();
    chk("b_ce0_pin", pin_b, 1'b1);
    chk("b_ce0_drive", u_b.drive, 1'b1);
    chk("b_ce0_din0", b_din0, 1'b1);
    b_ce = 1'b1;
    tick();
    chk("b_oe_off", u_b.drive, 1'b0);
    chk("b_din0_last", b_din0, 1'b1);
    b_oe = 1'b1; b_d0 = 1'b1;
    tick();

    // C: DDR output (registered when DDR is not built)
    c_d0 = 1'b1; c_d1 = 1'b0;
    tick();
    chk("c_pin_high", pin_c, 1'b1);
    @(negedge clk);
    #1;
    chk("c_pin_low", pin_c, !DDR);
    chk("c_din1", c_din1, DDR);
    tick();
    chk("c_pin_high2", pin_c, 1'b1);
    chk("c_din0", c_din0, !DDR);

    // Reset while B and C drive 1
    reset = 1'b1;
    tick();
    chk("rstk_b_hiz", u_b.drive, 1'b0);
    chk("rstk_b_din0", b_din0, 1'b0);
    chk("rstk_c_pin", pin_c, 1'b0);
    chk("rstk_c_din0", c_din0, 1'b0);
    tick();
    chk("rstk_c_pin_held", pin_c, 1'b0);
    reset = 1'b0;

    // D: registered-latched input
    d_val = 1'b1;
    tick();
    tick();
    chk("d_din0_1", d_din0, 1'b1);
    d_latch = 1'b1;
    tick();
    d_val = 1'b0;
    tick();
    chk("d_latched", d_din0, 1'b1);
    tick();
    chk("d_latched2", d_din0, 1'b1);
    d_latch = 1'b0;
    tick();
    chk("d_released", d_din0, 1'b0);
    d_val = 1'b1;
    tick();
    chk("d_follow", d_din0, 1'b1);
    d_latch = 1'b1; reset = 1'b1;
    tick();
    chk("d_reset_over_latch", d_din0, 1'b0);
    reset = 1'b0; d_latch = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
